// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit: branch funct3 codes and FSM states.
package bru_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    BRU_IDLE  = 1'b0,
    BRU_FLUSH = 1'b1
  } bruState_t;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch-condition evaluation: maps funct3 plus comparator flags to the
// taken outcome, selects unsigned compare mode and flags reserved funct3 encodings.
module br_cond_eval
  import bru_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       brEq,
  input  logic       brLt,
  output logic       taken,
  output logic       brUn,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:          taken = brEq;
      F3_BNE:          taken = !brEq;
      F3_BLT, F3_BLTU: taken = brLt;
      F3_BGE, F3_BGEU: taken = !brLt;
      default:         illegal = 1'b1;
    endcase
  end

  // Compare mode depends only on funct3 so the comparator can settle before BrLt is used.
  assign brUn = (funct3 == F3_BLTU) || (funct3 == F3_BGEU);

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolution with registered PC redirect and IF/ID flush sequencing.
// Optional saturating performance counters are built when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic [2:0]       ex_funct3,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             BrEq,
  input  logic             BrLt,
  output logic             BrUn,
  output logic             br_taken,
  output logic             illegal_br,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_mispred
);

  localparam int FCW = $clog2(FLUSH_CYCLES + 1);

  bruState_t       stateReg, stateNext;
  logic [FCW-1:0]  flushCntReg, flushCntNext;
  logic            redirectValidReg, redirectValidNext;
  logic [XLEN-1:0] redirectPcReg, redirectPcNext;
  logic            flushIfReg, flushIfNext;
  logic            flushIdReg, flushIdNext;

  logic            condTaken, condIllegal;
  logic            isJalr, isJal, isBranch, isCtl;
  logic            resolve, mispred;
  logic [XLEN-1:0] resolvedTarget;

  br_cond_eval uCondEval (
    .funct3  (ex_funct3),
    .brEq    (BrEq),
    .brLt    (BrLt),
    .taken   (condTaken),
    .brUn    (BrUn),
    .illegal (condIllegal)
  );

  // Malformed multi-hot decode falls back to jalr > jal > branch.
  assign isJalr   = ex_is_jalr;
  assign isJal    = ex_is_jal & !ex_is_jalr;
  assign isBranch = ex_is_branch & !ex_is_jal & !ex_is_jalr;
  assign isCtl    = isJalr | isJal | isBranch;

  assign br_taken   = isJalr | isJal | (isBranch & condTaken);
  assign illegal_br = ex_valid & isBranch & condIllegal;

  assign resolve = ex_valid & !ex_stall & isCtl & (stateReg == BRU_IDLE);
  // A predicted-taken JALR used a guessed target, so it always redirects.
  assign mispred = resolve & ((br_taken != ex_pred_taken) | (isJalr & ex_pred_taken));

  always_comb begin
    resolvedTarget = ex_pc + XLEN'(4);
    if (isJalr)
      resolvedTarget = {ex_target[XLEN-1:1], 1'b0};
    else if (br_taken)
      resolvedTarget = ex_target;
  end

  always_comb begin
    stateNext         = stateReg;
    flushCntNext      = flushCntReg;
    redirectValidNext = 1'b0;
    redirectPcNext    = redirectPcReg;
    flushIfNext       = 1'b0;
    flushIdNext       = flushIdReg;
    case (stateReg)
      BRU_IDLE: begin
        flushIdNext = 1'b0;
        if (mispred) begin
          stateNext         = BRU_FLUSH;
          redirectValidNext = 1'b1;
          redirectPcNext    = resolvedTarget;
          flushIfNext       = 1'b1;
          flushIdNext       = 1'b1;
          flushCntNext      = FCW'(FLUSH_CYCLES - 1);
        end
      end
      BRU_FLUSH: begin
        if (flushCntReg != '0) begin
          flushIdNext  = 1'b1;
          flushCntNext = flushCntReg - FCW'(1);
        end else begin
          stateNext   = BRU_IDLE;
          flushIdNext = 1'b0;
        end
      end
      default: begin
        stateNext   = BRU_IDLE;
        flushIdNext = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg         <= BRU_IDLE;
      flushCntReg      <= '0;
      redirectValidReg <= 1'b0;
      redirectPcReg    <= '0;
      flushIfReg       <= 1'b0;
      flushIdReg       <= 1'b0;
    end else begin
      stateReg         <= stateNext;
      flushCntReg      <= flushCntNext;
      redirectValidReg <= redirectValidNext;
      redirectPcReg    <= redirectPcNext;
      flushIfReg       <= flushIfNext;
      flushIdReg       <= flushIdNext;
    end
  end

  assign redirect_valid = redirectValidReg;
  assign redirect_pc    = redirectPcReg;
  assign flush_if       = flushIfReg;
  assign flush_id       = flushIdReg;

`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] perfBranchesReg, perfMispredReg;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perfBranchesReg <= '0;
      perfMispredReg  <= '0;
    end else begin
      if (resolve && (perfBranchesReg != '1))
        perfBranchesReg <= perfBranchesReg + CNT_W'(1);
      if (mispred && (perfMispredReg != '1))
        perfMispredReg <= perfMispredReg + CNT_W'(1);
    end
  end

  assign perf_branches = perfBranchesReg;
  assign perf_mispred  = perfMispredReg;
`else
  assign perf_branches = '0;
  assign perf_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized self-checking bench for branch_resolve_unit against a behavioural model.
// Build with +define+BRU_PERF_CNT_EN to exercise the saturating counters.
module tb_branch_resolve_unit;

  localparam int XLEN = 32;
  localparam int FC   = 2;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [2:0]      ex_funct3;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pc, ex_target;
  logic            BrEq, BrLt;
  logic            BrUn, br_taken, illegal_br;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush_if, flush_id;
  logic [CW-1:0]   perf_branches, perf_mispred;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_stall       (ex_stall),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jal      (ex_is_jal),
    .ex_is_jalr     (ex_is_jalr),
    .ex_funct3      (ex_funct3),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .BrEq           (BrEq),
    .BrLt           (BrLt),
    .BrUn           (BrUn),
    .br_taken       (br_taken),
    .illegal_br     (illegal_br),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_if       (flush_if),
    .flush_id       (flush_id),
    .perf_branches  (perf_branches),
    .perf_mispred   (perf_mispred)
  );

  int assertCnt = 0;
  int failCnt   = 0;

  // Model state: number of cycles flush_id stays high (== wrong-path shadow length).
  int          flushLeft;
  logic        mRv, mFi;
  logic [31:0] mPc;
  int          mPerfB, mPerfM;

`ifdef BRU_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Architectural meaning of each branch on the real operands.
  function automatic bit refTaken(input int kind, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] b);
    if (kind == 2 || kind == 3) return 1'b1;
    if (kind == 0) return 1'b0;
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic modelReset();
    flushLeft = 0; mRv = 0; mFi = 0; mPc = '0; mPerfB = 0; mPerfM = 0;
  endtask

  // kind: 0 none, 1 B-type, 2 JAL, 3 JALR. a/b are the register operands fed to the comparator.
  task automatic doCycle(input bit valid, input bit stall, input int kind, input logic [2:0] f3,
                         input bit pred, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic [31:0] a, input logic [31:0] b);
    bit          expTaken, expUn, expIll, resolve, mis;
    logic [31:0] expTgt;
    @(negedge clk);
    ex_valid = valid; ex_stall = stall;
    ex_is_branch = (kind == 1); ex_is_jal = (kind == 2); ex_is_jalr = (kind == 3);
    ex_funct3 = f3; ex_pred_taken = pred; ex_pc = pc; ex_target = tgt;
    #1;
    BrEq = (a == b);
    BrLt = BrUn ? (a < b) : ($signed(a) < $signed(b));
    #1;
    expTaken = refTaken(kind, f3, a, b);
    expUn    = (f3 == 3'd6) || (f3 == 3'd7);
    expIll   = valid && (kind == 1) && (f3 == 3'd2 || f3 == 3'd3);
    expectEq("BrUn", BrUn, expUn);
    expectEq("br_taken", br_taken, expTaken);
    expectEq("illegal_br", illegal_br, expIll);
    expectEq("redirect_valid", redirect_valid, mRv);
    expectEq("redirect_pc", redirect_pc, mPc);
    expectEq("flush_if", flush_if, mFi);
    expectEq("flush_id", flush_id, flushLeft > 0);
    expectEq("perf_branches", perf_branches, PerfEn ? mPerfB : 0);
    expectEq("perf_mispred", perf_mispred, PerfEn ? mPerfM : 0);

    resolve = valid && !stall && (kind != 0) && (flushLeft == 0);
    mis     = resolve && ((expTaken != pred) || (kind == 3 && pred));
    if (kind == 3)     expTgt = tgt & 32'hFFFF_FFFE;
    else if (expTaken) expTgt = tgt;
    else               expTgt = pc + 32'd4;

    @(posedge clk);
    if (flushLeft > 0) begin
      flushLeft--; mRv = 0; mFi = 0;
    end else if (mis) begin
      flushLeft = FC; mRv = 1; mFi = 1; mPc = expTgt;
    end else begin
      mRv = 0; mFi = 0;
    end
    if (resolve && mPerfB < (1 << CW) - 1) mPerfB++;
    if (mis && mPerfM < (1 << CW) - 1) mPerfM++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) doCycle(0, 0, 0, 3'd0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic resetNow();
    #2;
    rst_n = 1'b0;
    ex_valid = 1'b0;
    #1;
    expectEq("rst_redirect_valid", redirect_valid, 1'b0);
    expectEq("rst_redirect_pc", redirect_pc, 32'h0);
    expectEq("rst_flush_if", flush_if, 1'b0);
    expectEq("rst_flush_id", flush_id, 1'b0);
    expectEq("rst_perf_branches", perf_branches, 0);
    expectEq("rst_perf_mispred", perf_mispred, 0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] a, b, pc;
    int kind;
    rst_n = 1'b0;
    ex_valid = 0; ex_stall = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
    ex_funct3 = 0; ex_pred_taken = 0; ex_pc = 0; ex_target = 0; BrEq = 0; BrLt = 0;
    modelReset();
    #1;
    expectEq("rst_redirect_valid", redirect_valid, 1'b0);
    expectEq("rst_flush_id", flush_id, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // BEQ taken, predicted not-taken: redirect to 0x180, flush_id two cycles.
    doCycle(1, 0, 1, 3'd0, 0, 32'h100, 32'h180, 32'd5, 32'd5);
    idle(4);
    expectEq("beq_redirect_pc", redirect_pc, 32'h180);

    // BLTU (unsigned 1 < max) predicted taken; BLT (signed 1 < -1 false) predicted not-taken;
    // BGE taken, predicted taken: none redirect.
    doCycle(1, 0, 1, 3'd6, 1, 32'h200, 32'h300, 32'd1, 32'hFFFF_FFFF);
    doCycle(1, 0, 1, 3'd4, 0, 32'h204, 32'h300, 32'd1, 32'hFFFF_FFFF);
    doCycle(1, 0, 1, 3'd5, 1, 32'h208, 32'h300, 32'd5, 32'd3);
    idle(1);

    // BNE not taken but predicted taken at top of memory: fall-through wraps to 0.
    doCycle(1, 0, 1, 3'd1, 1, 32'hFFFF_FFFC, 32'h40, 32'd7, 32'd7);
    idle(1);
    expectEq("wrap_redirect_pc", redirect_pc, 32'h0);
    idle(3);

    // JALR to odd target, then a second mispredict in its shadow.
    doCycle(1, 0, 3, 3'd0, 0, 32'h400, 32'h203, 32'd0, 32'd0);
    doCycle(1, 0, 1, 3'd0, 0, 32'h404, 32'h500, 32'd1, 32'd1);
    idle(4);
    expectEq("jalr_redirect_pc", redirect_pc, 32'h202);

    // Illegal funct3 and a stalled mispredict, then the same instruction released.
    doCycle(1, 0, 1, 3'd2, 0, 32'h600, 32'h700, 32'd0, 32'd0);
    doCycle(1, 1, 2, 3'd0, 0, 32'h604, 32'h800, 32'd0, 32'd0);
    doCycle(1, 0, 2, 3'd0, 0, 32'h604, 32'h800, 32'd0, 32'd0);
    resetNow();
    idle(2);

    // 20 resolved JALs, three of them mispredicted (each followed by its flush shadow).
    for (int i = 0; i < 20; i++) begin
      if (i == 4 || i == 11 || i == 17) begin
        doCycle(1, 0, 2, 3'd0, 0, 32'h1000 + 32'(i * 4), 32'h2000, 32'd0, 32'd0);
        idle(FC);
      end else begin
        doCycle(1, 0, 2, 3'd0, 1, 32'h1000 + 32'(i * 4), 32'h2000, 32'd0, 32'd0);
      end
    end
    idle(1);
    expectEq("perf_branches_sat", perf_branches, PerfEn ? 4'd15 : 4'd0);
    expectEq("perf_mispred_cnt", perf_mispred, PerfEn ? 4'd3 : 4'd0);
    resetNow();

    for (int i = 0; i < 400; i++) begin
      kind = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 3)) : 0;
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      doCycle($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, kind,
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), pc, $urandom, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
